// File: rtl/hedios_pkg.sv
// Shared constants and types for the HEDIOS packet assembler.
package hedios_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame: sync, command, then four data bytes (MSB first).
  localparam int FRAME_LEN  = 6;
  localparam int DATA_BYTES = FRAME_LEN - 2;

  // Index value of the data byte that completes a frame.
  localparam logic [1:0] LAST_DATA_IDX = 2'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_CMD   = 2'd1,
    GET_DATA  = 2'd2
  } state_t;

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/hedios_idle_timer.sv
// Idle-cycle counter: counts while enabled, cleared on demand, and flags
// expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
module hedios_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Count idle cycles; a clear wins over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // A clearing event (a valid byte) in the expiry cycle suppresses expiry.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/hedios_packet_assembler.sv
// Byte-stream frame assembler: finds SYNC_BYTE, collects a command and a
// 32-bit data word, and pushes the result to a packet FIFO. Incomplete
// frames are abandoned after an idle timeout; full-FIFO frames are counted.
module hedios_packet_assembler
  import hedios_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_fifo_full,
  output logic        o_push_packet,
  output logic [7:0]  o_packet_command,
  output logic [31:0] o_packet_data,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_drop_count
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  data_idx;
  logic [7:0]  cmd_sh;
  logic [23:0] data_sh;

  logic        idle_expired;
  logic        cmd_load;
  logic        shift_en;
  logic        frame_done;
  logic        abandon;

  // The idle counter runs only inside a frame; any valid byte restarts it,
  // which also covers entry to GET_CMD (always caused by the sync byte).
  hedios_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (i_byte_valid || (state == WAIT_SYNC)),
    .enable (state != WAIT_SYNC),
    .expired(idle_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a valid byte always takes priority over timeout.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: begin
        if (i_byte_valid && (i_byte == SYNC_BYTE)) state_next = GET_CMD;
      end
      GET_CMD: begin
        if (i_byte_valid)      state_next = GET_DATA;
        else if (idle_expired) state_next = WAIT_SYNC;
      end
      GET_DATA: begin
        if (i_byte_valid && (data_idx == LAST_DATA_IDX)) state_next = WAIT_SYNC;
        else if (idle_expired)                           state_next = WAIT_SYNC;
      end
      default: state_next = WAIT_SYNC;
    endcase
  end

  // Per-state decode of byte handling and frame events.
  always_comb begin
    cmd_load   = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    abandon    = 1'b0;
    o_busy     = (state != WAIT_SYNC);
    case (state)
      GET_CMD: begin
        cmd_load = i_byte_valid;
        abandon  = idle_expired;
      end
      GET_DATA: begin
        shift_en   = i_byte_valid;
        frame_done = i_byte_valid && (data_idx == LAST_DATA_IDX);
        abandon    = idle_expired;
      end
      default: ;
    endcase
  end

  // Frame payload capture; contents are don't-care until a frame completes.
  always_ff @(posedge clk) begin
    if (cmd_load) cmd_sh <= i_byte;
    if (shift_en) data_sh <= {data_sh[15:0], i_byte};
  end

  // Byte index, push/timeout strobes, packet outputs and drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_idx         <= 2'd0;
      o_push_packet    <= 1'b0;
      o_timeout        <= 1'b0;
      o_packet_command <= 8'd0;
      o_packet_data    <= 32'd0;
      o_drop_count     <= 8'd0;
    end else begin
      o_push_packet <= frame_done && !i_fifo_full;
      o_timeout     <= abandon;
      if (cmd_load) begin
        data_idx <= 2'd0;
      end else if (shift_en) begin
        data_idx <= data_idx + 2'd1;
      end
      if (frame_done && !i_fifo_full) begin
        o_packet_command <= cmd_sh;
        o_packet_data    <= {data_sh, i_byte};
      end
      if (frame_done && i_fifo_full) begin
        o_drop_count <= sat_inc8(o_drop_count);
      end
    end
  end

endmodule

// File: tb/tb_hedios_packet_assembler.sv
// Testbench for hedios_packet_assembler: directed vector table, hand-written
// corner sequences, and random traffic against a frame-level reference model.
module tb_hedios_packet_assembler;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        i_fifo_full;
  logic        o_push_packet;
  logic [7:0]  o_packet_command;
  logic [31:0] o_packet_data;
  logic        o_busy;
  logic        o_timeout;
  logic [7:0]  o_drop_count;

  hedios_packet_assembler #(
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_byte_valid    (i_byte_valid),
    .i_byte          (i_byte),
    .i_fifo_full     (i_fifo_full),
    .o_push_packet   (o_push_packet),
    .o_packet_command(o_packet_command),
    .o_packet_data   (o_packet_data),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout),
    .o_drop_count    (o_drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the bytes of the frame in progress, held as a list.
  logic [7:0]  fb[$];
  int          m_idle;
  logic        m_push, m_to;
  logic [7:0]  m_cmd, m_drop;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fb.delete();
    m_idle = 0; m_push = 0; m_to = 0;
    m_cmd = 8'd0; m_data = 32'd0; m_drop = 8'd0;
  endtask

  // Predicts the outputs seen just after the coming clock edge.
  task automatic model_update(input logic v, input logic [7:0] b, input logic f);
    m_push = 1'b0;
    m_to   = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (v) begin
      m_idle = 0;
      if (fb.size() == 0) begin
        if (b == SYNC) fb.push_back(b);
      end else begin
        fb.push_back(b);
        if (fb.size() == 6) begin
          if (f) begin
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          end else begin
            m_push = 1'b1;
            m_cmd  = fb[1];
            m_data = {fb[2], fb[3], fb[4], fb[5]};
          end
          fb.delete();
        end
      end
    end else if (fb.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        fb.delete();
        m_idle = 0;
        m_to   = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("push",    {31'd0, o_push_packet}, {31'd0, m_push});
    chk("timeout", {31'd0, o_timeout},     {31'd0, m_to});
    chk("busy",    {31'd0, o_busy},        {31'd0, (fb.size() > 0)});
    chk("cmd",     {24'd0, o_packet_command}, {24'd0, m_cmd});
    chk("data",    o_packet_data, m_data);
    chk("drops",   {24'd0, o_drop_count}, {24'd0, m_drop});
  endtask

  // One clock cycle of stimulus, checked against the model afterwards.
  task automatic step(input logic v, input logic [7:0] b, input logic f);
    i_byte_valid = v;
    i_byte       = b;
    i_fifo_full  = f;
    model_update(v, b, f);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data, input logic f);
    step(1'b1, SYNC, f);
    step(1'b1, cmd, f);
    step(1'b1, data[31:24], f);
    step(1'b1, data[23:16], f);
    step(1'b1, data[15:8], f);
    step(1'b1, data[7:0], f);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        f;
    logic        e_push;
    logic        e_busy;
    logic [7:0]  e_cmd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] b, input logic f,
                     input logic e_push, input logic e_busy,
                     input logic [7:0] e_cmd, input logic [31:0] e_data);
    vec_t r;
    r.v = v; r.b = b; r.f = f; r.e_push = e_push; r.e_busy = e_busy;
    r.e_cmd = e_cmd; r.e_data = e_data;
    tbl.push_back(r);
  endtask

  initial begin
    int pushes, tos, first_to, last_push;

    rst_n = 1'b0; i_byte_valid = 1'b0; i_byte = 8'd0; i_fifo_full = 1'b0;
    model_reset();

    // Basic frame, garbage then frame, back-to-back frames, sync as payload.
    add(1, 8'hA5, 0, 0, 1, 0, 0); add(1, 8'h10, 0, 0, 1, 0, 0);
    add(1, 8'hDE, 0, 0, 1, 0, 0); add(1, 8'hAD, 0, 0, 1, 0, 0);
    add(1, 8'hBE, 0, 0, 1, 0, 0); add(1, 8'hEF, 0, 1, 0, 8'h10, 32'hDEADBEEF);
    add(0, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'h5A, 0, 0, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 0, 0); add(1, 8'h20, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0); add(1, 8'h00, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0); add(1, 8'h01, 0, 1, 0, 8'h20, 32'h00000001);
    add(1, 8'hA5, 0, 0, 1, 0, 0); add(1, 8'h50, 0, 0, 1, 0, 0);
    add(1, 8'h01, 0, 0, 1, 0, 0); add(1, 8'h02, 0, 0, 1, 0, 0);
    add(1, 8'h03, 0, 0, 1, 0, 0); add(1, 8'h04, 0, 1, 0, 8'h50, 32'h01020304);
    add(1, 8'hA5, 0, 0, 1, 0, 0); add(1, 8'h60, 0, 0, 1, 0, 0);
    add(1, 8'h05, 0, 0, 1, 0, 0); add(1, 8'h06, 0, 0, 1, 0, 0);
    add(1, 8'h07, 0, 0, 1, 0, 0); add(1, 8'h08, 0, 1, 0, 8'h60, 32'h05060708);
    add(1, 8'hA5, 0, 0, 1, 0, 0); add(1, 8'hA5, 0, 0, 1, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 0, 0); add(0, 8'h00, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0); add(1, 8'h00, 0, 0, 1, 0, 0);
    add(1, 8'hA5, 0, 1, 0, 8'hA5, 32'hA50000A5);

    // Reset state.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, SYNC, 1'b0);
    rst_n = 1'b1;
    chk("rst_push", {31'd0, o_push_packet}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_data", o_packet_data, 32'd0);
    chk("rst_drop", {24'd0, o_drop_count}, 32'd0);

    // Directed vector table.
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].b, tbl[i].f);
      chk($sformatf("tbl%0d_push", i), {31'd0, o_push_packet}, {31'd0, tbl[i].e_push});
      chk($sformatf("tbl%0d_busy", i), {31'd0, o_busy}, {31'd0, tbl[i].e_busy});
      if (tbl[i].e_push) begin
        chk($sformatf("tbl%0d_cmd", i), {24'd0, o_packet_command}, {24'd0, tbl[i].e_cmd});
        chk($sformatf("tbl%0d_data", i), o_packet_data, tbl[i].e_data);
      end
    end

    // Back-to-back frames: pushes exactly six cycles apart.
    pushes = 0; last_push = -100;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, (k % 6 == 0) ? SYNC : 8'(k), 1'b0);
      if (o_push_packet) begin
        if (pushes > 0) chk("b2b_gap", k - last_push, 6);
        pushes++; last_push = k;
      end
    end
    chk("b2b_pushes", pushes, 2);

    // Partial frame abandoned after TMO idle cycles.
    step(1'b1, SYNC, 1'b0); step(1'b1, 8'h30, 1'b0); step(1'b1, 8'h11, 1'b0);
    tos = 0; first_to = -1; pushes = 0;
    for (int k = 1; k <= TMO + 10; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (o_timeout) begin tos++; if (first_to < 0) first_to = k; end
      if (o_push_packet) pushes++;
    end
    chk("to_count", tos, 1);
    chk("to_cycle", first_to, TMO);
    chk("to_push", pushes, 0);
    chk("to_busy", {31'd0, o_busy}, 32'd0);
    send_frame(8'h31, 32'hCAFEBABE, 1'b0);
    chk("after_to_push", {31'd0, o_push_packet}, 32'd1);
    chk("after_to_data", o_packet_data, 32'hCAFEBABE);

    // Byte arriving on the expiry cycle counts as a byte.
    step(1'b1, SYNC, 1'b0); step(1'b1, 8'h32, 1'b0);
    tos = 0;
    for (int k = 1; k < TMO; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (o_timeout) tos++;
    end
    step(1'b1, 8'h99, 1'b0);
    if (o_timeout) tos++;
    chk("edge_no_to", tos, 0);
    chk("edge_busy", {31'd0, o_busy}, 32'd1);
    step(1'b1, 8'h88, 1'b0); step(1'b1, 8'h77, 1'b0); step(1'b1, 8'h66, 1'b0);
    chk("edge_data", o_packet_data, 32'h99887766);

    // 300 dropped frames saturate the counter with no push.
    pushes = 0;
    for (int k = 0; k < 300; k++) begin
      send_frame(8'(k), 32'(k), 1'b1);
      if (o_push_packet) pushes++;
    end
    chk("drop_push", pushes, 0);
    chk("drop_sat", {24'd0, o_drop_count}, 32'd255);
    chk("drop_hold", o_packet_data, 32'h99887766);

    // Reset mid-frame: no push, no timeout, then a clean frame.
    step(1'b1, SYNC, 1'b0); step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tos = 0; pushes = 0;
    for (int k = 0; k < TMO + 5; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (o_timeout) tos++;
      if (o_push_packet) pushes++;
    end
    chk("rstmid_to", tos, 0);
    chk("rstmid_push", pushes, 0);
    send_frame(8'h41, 32'h00000007, 1'b0);
    chk("rstmid_cmd", {24'd0, o_packet_command}, 32'h41);
    chk("rstmid_data", o_packet_data, 32'h7);

    // Random traffic against the model.
    for (int k = 0; k < 6000; k++) begin
      logic       v, f;
      logic [7:0] b;
      int         r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        for (int g = 0; g < 995 + int'($urandom_range(0, 10)); g++)
          step(1'b0, 8'h00, 1'b0);
      end else if (r < 6) begin
        rst_n = 1'b0;
        step($urandom_range(0, 1) == 1, SYNC, 1'b0);
        rst_n = 1'b1;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        f = ($urandom_range(0, 3) == 0);
        b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
        step(v, b, f);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hedios_packet_assembler.md
HEDIOS_PACKET_ASSEMBLER -- requirements
Module: hedios_packet_assembler

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum idle cycles between bytes inside a frame; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_byte_valid  input  1  i_byte is valid this cycle; no backpressure, one byte per cycle maximum.
REQ-006 SHALL have port i_byte  input  8  received byte.
REQ-007 SHALL have port i_fifo_full  input  1  full flag of the downstream packet FIFO.
REQ-008 SHALL have port o_push_packet  output  1  one-cycle push strobe to the packet FIFO.
REQ-009 SHALL have port o_packet_command  output  8  assembled command byte.
REQ-010 SHALL have port o_packet_data  output  32  assembled data word.
REQ-011 SHALL have port o_busy  output  1  high in any state other than WAIT_SYNC.
REQ-012 SHALL have port o_timeout  output  1  one-cycle pulse when a partial frame is abandoned.
REQ-013 SHALL have port o_drop_count  output  8  saturating count of complete frames dropped because the FIFO was full.

Function
REQ-014 Frame format SHALL be SYNC_BYTE, command, data[31:24], data[23:16], data[15:8], data[7:0], transmitted MSB byte first.
REQ-015 FSM states SHALL be WAIT_SYNC, GET_CMD, GET_DATA.
REQ-016 WAIT_SYNC: a valid byte equal to SYNC_BYTE -> GET_CMD; any other valid byte is discarded.
REQ-017 GET_CMD: a valid byte is latched as the command -> GET_DATA, with byte index 0; a SYNC_BYTE value here is data, not a resync.
REQ-018 GET_DATA: each valid byte shifts into the data register (data <= {data[23:0], byte}) and increments a 2-bit index; the byte at index 3 completes the frame -> WAIT_SYNC.
REQ-019 On frame completion with i_fifo_full low in that same cycle, o_push_packet SHALL be high for exactly the next cycle, with o_packet_command/o_packet_data holding the frame (latency 1 cycle from last byte).
REQ-020 On frame completion with i_fifo_full high, the frame SHALL be dropped, no push issued, and o_drop_count incremented, saturating at 255.
REQ-021 o_packet_command/o_packet_data SHALL update only on a pushing completion and hold otherwise.
REQ-022 A 16-bit idle counter SHALL reset on every valid byte and on entry to GET_CMD; in GET_CMD/GET_DATA, reaching TIMEOUT_CYCLES without a valid byte -> WAIT_SYNC with o_timeout pulsed for one cycle, partial data discarded.
REQ-023 A valid byte in the cycle o_push_packet is high SHALL be processed normally in WAIT_SYNC (back-to-back frames, no gap cycle).
REQ-024 A valid byte and timeout expiry in the same cycle SHALL count as the byte; no timeout is raised.

Reset
REQ-025 When rst_n is low at a clock edge: state WAIT_SYNC, o_push_packet 0, o_packet_command 0, o_packet_data 0, o_timeout 0, o_drop_count 0, index 0, idle counter 0.
REQ-026 Reset mid-frame SHALL discard the partial frame, issue no push and no timeout pulse.

Structure
REQ-027 SYNC_BYTE default value, frame length (6), and the FSM state encoding SHALL live in the shared hedios_pkg package.
REQ-028 A sub-module hedios_idle_timer (counter, clear, expiry compare) is natural; everything else SHALL be flat.

Verification
REQ-029 A5 10 DE AD BE EF, 1 byte/cycle, full=0 -> one push, cmd=8'h10, data=32'hDEADBEEF, 1 cycle after EF.
REQ-030 Garbage 00 FF 5A, then A5 20 00 00 00 01 -> garbage ignored, single push cmd=8'h20 data=32'h1.
REQ-031 Two back-to-back frames, second A5 in the push cycle -> two pushes, 6 cycles apart.
REQ-032 A5 30 11, then 1000 idle cycles -> o_timeout pulses once, o_busy falls, no push; a following full frame pushes correctly.
REQ-033 Frame completing with i_fifo_full=1, repeated 300 times -> no pushes, o_drop_count=255 (saturated).
REQ-034 rst_n low after A5 40 01 02 -> no push and no timeout; a following frame A5 41 00 00 00 07 -> cmd=8'h41 data=32'h7.
